// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_W    = 32;
    localparam int unsigned DIV_ITER = DIV_W;
    localparam logic [DIV_W-1:0] MIN_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_e;

    function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v, input logic sgn);
        return (sgn && v[DIV_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,q} left, trial-subtract, select.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_W
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] dvsr_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] trial;

    // rem < dvsr always holds, so W+1 bits suffice and trial[W] is the borrow.
    always_comb begin
        shifted = {rem_i, quo_i[DATA_WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_i};
        quo_o   = {quo_i[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
        rem_o   = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional macro DIVIDER_EARLY_OUT_EN skips CALC for zero divisor or |dividend| < |divisor|.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_ITER
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sign,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_zero,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    if (DATA_WIDTH != DIV_W) begin : g_width_chk
        $error("seq_divider: DATA_WIDTH must equal div_pkg::DIV_W");
    end

    div_state_e state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  dz_pend_q, dz_pend_d;
    logic                  ovf_pend_q, ovf_pend_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
    logic                  div_zero_q, div_zero_d;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] dvnd_abs;
    logic [DATA_WIDTH-1:0] dvsr_abs;
    logic [DATA_WIDTH-1:0] step_rem;
    logic [DATA_WIDTH-1:0] step_quo;

    div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvsr_i(dvsr_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        dvnd_abs    = abs_val(dividend, sign);
        dvsr_abs    = abs_val(divisor, sign);

        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_pend_d   = dz_pend_q;
        ovf_pend_d  = ovf_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    neg_quo_d  = sign & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                    neg_rem_d  = sign & dividend[DATA_WIDTH-1];
                    dz_pend_d  = (divisor == '0);
                    ovf_pend_d = sign && (dividend == MIN_NEG) && (divisor == '1);
                    rem_d      = '0;
                    quo_d      = dvnd_abs;
                    dvsr_d     = dvsr_abs;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = CALC;
`ifdef DIVIDER_EARLY_OUT_EN
                    // Preload what the full iteration would have converged to.
                    if ((divisor == '0) || (dvnd_abs < dvsr_abs)) begin
                        rem_d   = dvnd_abs;
                        quo_d   = (divisor == '0) ? '1 : '0;
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Zero divisor keeps the raw all-ones quotient; remainder fixup restores the dividend.
                quotient_d  = dz_pend_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                div_zero_d  = dz_pend_q;
                overflow_d  = ovf_pend_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_pend_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_pend_q   <= dz_pend_d;
            ovf_pend_q  <= ovf_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic        overflow;

    int n_chk  = 0;
    int n_pass = 0;

    seq_divider #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
        int signed sa, sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = 32'h8000_0000;
            r  = 32'd0;
            ov = 1'b1;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] ma, mb;
        ma  = (sgn && a[31]) ? 32'd0 - a : a;
        mb  = (sgn && b[31]) ? 32'd0 - b : b;
        lat = 34;
`ifdef DIVIDER_EARLY_OUT_EN
        if (b == 32'd0 || ma < mb) lat = 2;
`else
        if (ma == 32'd0 && mb == 32'd0) lat = 34;
`endif
        return lat;
    endfunction

    task automatic check_results(input string tag, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b);
        logic [31:0] eq, er;
        logic edz, eov;
        model(sgn, a, b, eq, er, edz, eov);
        chk({tag, ".q"}, quotient, eq);
        chk({tag, ".r"}, remainder, er);
        chk({tag, ".dz"}, 32'(div_zero), 32'(edz));
        chk({tag, ".ov"}, 32'(overflow), 32'(eov));
    endtask

    task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b);
        int edges, bcyc, lat;
        lat = exp_latency(sgn, a, b);
        @(negedge clk);
        sign = sgn; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        bcyc  = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (busy) bcyc++;
        end
        chk({tag, ".lat"}, 32'(edges), 32'(lat));
        chk({tag, ".busy"}, 32'(bcyc), 32'(lat - 1));
        check_results(tag, sgn, a, b);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'(done), 32'd0);
        check_results({tag, ".hold"}, sgn, a, b);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b, a2, b2;
        int edges, dones, lat;

        rst_n = 1'b0; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.q", quotient, 32'd0);
        chk("rst.r", remainder, 32'd0);
        chk("rst.flags", {30'd0, div_zero, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("u100_7", 1'b0, 32'd100, 32'd7);
        do_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("s_dz", 1'b1, 32'h1234_5678, 32'd0);
        do_op("u_dz", 1'b0, 32'h1234_5678, 32'd0);
        do_op("s_dzneg", 1'b1, 32'h8765_4321, 32'd0);
        do_op("s_small", 1'b1, 32'hFFFF_FFFD, 32'd10);
        do_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1);

        // start held high: second op is accepted in the done cycle
        a = 32'd1000; b = 32'd33; a2 = 32'hF000_0000; b2 = 32'hFFFF_FFF0;
        @(negedge clk);
        sign = 1'b0; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        dividend = a2; divisor = b2; sign = 1'b1;
        edges = 1;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("b2b.lat1", 32'(edges), 32'(exp_latency(1'b0, a, b)));
        check_results("b2b.op1", 1'b0, a, b);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!done && edges < 100);
        start = 1'b0;
        chk("b2b.lat2", 32'(edges), 32'(exp_latency(1'b1, a2, b2)));
        check_results("b2b.op2", 1'b1, a2, b2);
        @(posedge clk); #1;
        chk("b2b.idle", {30'd0, busy, done}, 32'd0);

        // start pulses while busy are dropped
        a = 32'hDEAD_BEEF; b = 32'd13;
        lat = exp_latency(1'b0, a, b);
        @(negedge clk);
        sign = 1'b0; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int k = 1; k < 60; k++) begin
            @(negedge clk);
            if (k < lat && (k % 4) == 1) begin
                start = 1'b1; sign = 1'(($urandom % 2)); dividend = $urandom; divisor = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                dones++;
                check_results("ign.res", 1'b0, a, b);
            end
        end
        start = 1'b0;
        chk("ign.dones", 32'(dones), 32'd1);
        chk("ign.busy", 32'(busy), 32'd0);

        // asynchronous reset at CALC step 10
        @(negedge clk);
        sign = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(done), 32'd0);
        chk("arst.q", quotient, 32'd0);
        chk("arst.r", remainder, 32'd0);
        chk("arst.flags", {30'd0, div_zero, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("arst.nodone", 32'(dones), 32'd0);
        do_op("arst.after", 1'b1, 32'hFFFF_FC18, 32'd7);

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom % 2);
            a   = $urandom;
            b   = $urandom;
            case ($urandom % 7)
                0: b = 32'd0;
                1: b = $urandom % 16;
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: a = $urandom % 100;
                5: b = a >> ($urandom % 8);
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), sgn, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle 32-bit restoring divider for the single-cycle MIPS datapath.
- Implements DIV/DIVU: consumes operands, produces quotient (LO) and remainder (HI).
- Uses one subtract-and-restore step per clock, the inverse direction of the existing combinational add/subtract unit.
- Sits beside the ALU. Control stalls the PC while busy is high.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start
- dividend  input  DATA_WIDTH  numerator; captured with start
- divisor  input  DATA_WIDTH  denominator; captured with start
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle completion pulse
- quotient  output  DATA_WIDTH  result for LO
- remainder  output  DATA_WIDTH  result for HI
- div_zero  output  1  divisor was zero for the last operation
- overflow  output  1  signed -2^(W-1) / -1 for the last operation

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, overflow=0, iteration counter=0.
- Reset mid-operation aborts immediately. No done is produced.
- State IDLE:
  - start=1 latches operands and sign.
  - Signed mode converts the operands to magnitudes, using two's complement negate of negative values.
  - Records neg_q = dividend[W-1]^divisor[W-1] and neg_r = dividend[W-1].
  - Loads the partial remainder with 0 and the shift register with |dividend|.
  - Goes to CALC, counter=0.
- State CALC, one step per cycle:
  - Shift {rem,q} left by 1.
  - Compute trial = rem - |divisor| at width W+1.
  - If trial is non-negative, rem = trial and q[0] = 1; otherwise q[0] = 0.
  - Counter increments. After step W (counter==W-1), go to FIX.
- State FIX:
  - Applies signs: quotient = neg_q ? -q : q, remainder = neg_r ? -rem : rem.
  - Truncates toward zero; the remainder sign follows the dividend.
  - Registers the outputs and div_zero/overflow, pulses done=1 for the next cycle, and returns to IDLE.
- Latency: start accepted at edge N, done high in the cycle after edge N+W+1. Default W=32 gives 34 edges.
- busy is high from edge N through edge N+W+1.
- start while busy or in the done cycle's preceding edges is ignored, with no queuing.
- start in the same cycle done is high is accepted, because the state is already IDLE.
- quotient, remainder and flags hold from done until the next accepted start completes FIX.
- Divide by zero:
  - The full iteration runs and naturally yields q = all ones, rem = |dividend|, then sign fixup is applied.
  - Sign fixup for quotient is suppressed: quotient = all ones, remainder = dividend unchanged.
  - div_zero=1.
- Signed overflow: -2^(W-1) / -1 gives quotient = 0x80000000, remainder = 0, overflow = 1. The normal algorithm already yields this; the flag is purely a decode.
- The unsigned path never sets overflow.
- The magnitude of -2^(W-1) is 0x80000000, treated as unsigned inside the datapath.

Optional Feature:
- Macro DIVIDER_EARLY_OUT_EN.
- When defined: in IDLE, if divisor==0 or |dividend| < |divisor|, skip CALC and go straight to FIX, with done one cycle after FIX (2 edges total).
  - Divisor zero: results per the div-zero rule.
  - |dividend| < |divisor|: quotient = 0, remainder = dividend.
  - busy is high for that single FIX cycle.
- When undefined: every operation takes the full W+2 edges. Results are identical in both builds; only latency differs.

Decomposition:
- Shared package div_pkg:
  - State enum: IDLE, CALC, FIX.
  - Constants: DIV_ITER = DATA_WIDTH, MIN_NEG = 32'h80000000.
  - Function abs_val (conditional two's complement).
- One sub-module: div_step, a combinational single-iteration shift/trial-subtract/select producing the next {rem,q}. It keeps the FSM file small and is unit-testable.

Test Plan:
- Unsigned 100/7, sign=0 -> done after 34 edges, quotient=14, remainder=2, flags 0, busy high for 33 cycles.
- Signed -7/2 (0xFFFFFFF9, 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7/-2 -> quotient=-3, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1. The same operands with sign=0 -> quotient=0, remainder=0x80000000, overflow=0.
- Divisor 0, dividend 0x12345678 (both modes) -> quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1. With DIVIDER_EARLY_OUT_EN, done arrives 2 edges after start.
- Back-to-back:
  - start held high continuously -> second operation accepted in the done cycle.
  - start pulses during busy -> ignored, with exactly one done per accepted start.
- Assert rst_n low at CALC step 10 -> all outputs 0 immediately (asynchronous), no done. The next start after reset gives correct results.
